dotprod_issue_collect: RTL and testbench

Initiator/collector side for a dot-product core (the core computes result = c0*x0 + c1*x1). It accepts operand pairs on a valid/ready stream, drives them as registered, stable operands into the core for the core's latency, and captures the core's result. It then presents the result on a valid/ready output stream. It is the sequential harness that lets a synthesized dot-product core (combinational or pipelined) sit in a streaming datapath and in hardware tests.

---
 rtl/dotprod_pkg.sv | 16 +
 rtl/dotprod_issue_collect.sv | 129 ++++++++++++
 tb/tb_dotprod_issue_collect.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dotprod_pkg.sv
// Shared types and default widths for the dot-product issue/collect harness.
package dotprod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_IN_WIDTH  = 2;
    localparam int DEF_OUT_WIDTH = 4;

    typedef logic signed [DEF_IN_WIDTH-1:0]  operand_t;
    typedef logic signed [DEF_OUT_WIDTH-1:0] result_t;

endpackage

// File: rtl/dotprod_issue_collect.sv
// Issues one registered operand pair to a dot-product core, waits out the core
// latency, captures the result and hands it off on a valid/ready stream.
module dotprod_issue_collect
    import dotprod_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int LATENCY   = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_x0,
    input  logic signed [IN_WIDTH-1:0]  in_x1,
    output logic signed [IN_WIDTH-1:0]  core_x0,
    output logic signed [IN_WIDTH-1:0]  core_x1,
    input  logic signed [OUT_WIDTH-1:0] core_result,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_result,
    output logic                        busy,
    output logic [CNT_WIDTH-1:0]        txn_count
);

    localparam int WCW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [WCW-1:0]       WAIT_LOAD = WCW'(LATENCY);
    localparam logic [WCW-1:0]       WAIT_ONE  = WCW'(1);
    localparam logic [WCW-1:0]       WAIT_ZERO = WCW'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t         state_r;
    state_t         state_next_s;
    logic [WCW-1:0] wait_cnt_r;
    logic           in_fire_s;
    logic           out_fire_s;
    logic           wait_done_s;

    assign in_fire_s   = in_valid & in_ready;
    assign out_fire_s  = out_valid & out_ready;
    assign wait_done_s = (state_r == WAIT) && (wait_cnt_r == WAIT_ZERO);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; DONE may chain straight into WAIT on a back-to-back pair.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_next_s = WAIT;
                else          state_next_s = IDLE;
            end
            WAIT: begin
                if (wait_cnt_r == WAIT_ZERO) state_next_s = DONE;
                else                         state_next_s = WAIT;
            end
            DONE: begin
                if (out_ready) state_next_s = in_valid ? WAIT : IDLE;
                else           state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode; in_ready follows out_ready combinationally in DONE.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
            end
            WAIT: begin
                busy = 1'b1;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Operand registers and the latency countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_x0    <= '0;
            core_x1    <= '0;
            wait_cnt_r <= WAIT_ZERO;
        end else if (in_fire_s) begin
            core_x0    <= in_x0;
            core_x1    <= in_x1;
            wait_cnt_r <= WAIT_LOAD;
        end else if ((state_r == WAIT) && (wait_cnt_r != WAIT_ZERO)) begin
            wait_cnt_r <= wait_cnt_r - WAIT_ONE;
        end
    end

    // Result capture on the last WAIT cycle; held through DONE and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result <= '0;
        end else if (wait_done_s) begin
            out_result <= core_result;
        end
    end

    // Completed hand-off counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_count <= '0;
        end else if (out_fire_s) begin
            txn_count <= txn_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_dotprod_issue_collect.sv
// Scoreboard bench: lane 0 = combinational core (LATENCY 0, 2-bit count),
// lane 1 = 3-stage piped core (LATENCY 3, 16-bit count); core is c0=-2, c1=1.
module tb_dotprod_issue_collect;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0]       in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0][1:0]  in_x0, in_x1, core_x0, core_x1;
    logic [1:0][3:0]  core_result, out_result;
    logic [1:0][15:0] txn_count;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;
    bit rand_on = 1'b0;

    typedef struct {
        logic [1:0] x0;
        logic [1:0] x1;
        logic [3:0] res;
        int         acc;
    } item_t;

    item_t      sb [2][$];
    int         cnt_m    [2];
    logic [1:0] last_x0  [2];
    logic [1:0] last_x1  [2];
    logic [3:0] last_res [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int CW = (g == 0) ? 2 : 16;
        logic [3:0]    prod;
        logic [CW-1:0] tc;

        assign prod = {{2{core_x1[g][1]}}, core_x1[g]} - {core_x0[g][1], core_x0[g], 1'b0};
        assign txn_count[g] = 16'(tc);

        if (g == 0) begin : g_comb
            assign core_result[g] = prod;
        end else begin : g_pipe
            logic [3:0] p1, p2, p3;
            always @(posedge clk or posedge rst) begin
                if (rst) begin
                    p1 <= 4'd0; p2 <= 4'd0; p3 <= 4'd0;
                end else begin
                    p1 <= prod; p2 <= p1; p3 <= p2;
                end
            end
            assign core_result[g] = p3;
        end

        dotprod_issue_collect #(
            .IN_WIDTH(2), .OUT_WIDTH(4), .LATENCY((g == 0) ? 0 : 3), .CNT_WIDTH(CW)
        ) dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .in_x0(in_x0[g]), .in_x1(in_x1[g]),
            .core_x0(core_x0[g]), .core_x1(core_x1[g]),
            .core_result(core_result[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .out_result(out_result[g]), .busy(busy[g]), .txn_count(tc)
        );
    end

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : 3;
    endfunction

    function automatic int mod_of(input int g);
        return (g == 0) ? 4 : 65536;
    endfunction

    // Reference: signed arithmetic on integers, truncated to the 4-bit result.
    function automatic logic [3:0] model(input logic [1:0] a, input logic [1:0] b);
        int v;
        v = -2 * int'($signed(a)) + int'($signed(b));
        return 4'(v);
    endfunction

    function automatic void check(input string name, input int g,
                                  input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s lane%0d: got %0h expected %0h (cycle %0d)", name, g, act, exp, cyc);
    endfunction

    // Monitor: compares DUT against the transaction-level model each cycle.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin : mon
            bit    have;
            bit    ov_exp;
            item_t it;
            if (rst) begin
                sb[g].delete();
                cnt_m[g] = 0; last_x0[g] = 2'd0; last_x1[g] = 2'd0; last_res[g] = 4'd0;
                check("reset_state", g, {out_valid[g], busy[g], txn_count[g],
                      core_x0[g], core_x1[g], out_result[g]}, 64'd0);
            end else begin
                have   = (sb[g].size() != 0);
                ov_exp = have && (cyc - sb[g][0].acc >= lat_of(g) + 2);
                check("out_valid", g, out_valid[g], ov_exp);
                check("busy", g, busy[g], have);
                check("in_ready", g, in_ready[g], !have || (ov_exp && out_ready[g]));
                check("core_x", g, {core_x0[g], core_x1[g]}, {last_x0[g], last_x1[g]});
                check("txn_count", g, txn_count[g], cnt_m[g]);
                if (ov_exp) check("out_result", g, out_result[g], sb[g][0].res);
                else if (!have) check("idle_result", g, out_result[g], last_res[g]);
                if (out_valid[g] && out_ready[g] && have) begin
                    last_res[g] = sb[g][0].res;
                    void'(sb[g].pop_front());
                    cnt_m[g] = (cnt_m[g] + 1) % mod_of(g);
                end
                if (in_valid[g] && in_ready[g]) begin
                    it.x0 = in_x0[g]; it.x1 = in_x1[g];
                    it.res = model(in_x0[g], in_x1[g]); it.acc = cyc;
                    sb[g].push_back(it);
                    last_x0[g] = in_x0[g]; last_x1[g] = in_x1[g];
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Present a pair and hold it until accepted; leaves in_valid high on return.
    task automatic send(input int g, input logic [1:0] a, input logic [1:0] b);
        bit done;
        done = 1'b0;
        in_x0[g] = a; in_x1[g] = b; in_valid[g] = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = in_ready[g] && !rst;
            @(posedge clk); #1;
        end
        if (!done) check("send_timeout", g, 64'd0, 64'd1);
    endtask

    task automatic run_random(input int g, input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                in_valid[g] = 1'b0;
                cycles($urandom_range(1, 3));
            end
            send(g, 2'($urandom), 2'($urandom));
        end
        in_valid[g] = 1'b0;
    endtask

    initial begin
        in_valid = 2'b00; out_ready = 2'b00; in_x0 = '0; in_x1 = '0;
        cycles(3);
        rst = 1'b0;
        cycles(2);

        out_ready[0] = 1'b1;
        send(0, 2'b01, 2'b01); in_valid[0] = 1'b0;
        cycles(4);
        send(0, 2'b10, 2'b10); send(0, 2'b10, 2'b01); send(0, 2'b01, 2'b10);
        in_valid[0] = 1'b0;
        cycles(4);

        out_ready[1] = 1'b1;
        send(1, 2'b10, 2'b01); in_valid[1] = 1'b0;
        cycles(8);

        // Backpressure with a second pair waiting upstream the whole time.
        out_ready[0] = 1'b0;
        send(0, 2'b01, 2'b01);
        fork
            send(0, 2'b00, 2'b01);
            begin cycles(12); out_ready[0] = 1'b1; end
        join
        in_valid[0] = 1'b0;
        cycles(4);

        // Reset lands in the middle of lane 1's WAIT.
        send(1, 2'b01, 2'b01); in_valid[1] = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_reset", 1, {out_valid[1], busy[1], txn_count[1], core_x0[1], core_x1[1]}, 64'd0);
        cycles(2);
        rst = 1'b0;
        send(1, 2'b00, 2'b01); in_valid[1] = 1'b0;
        cycles(8);

        rand_on = 1'b1;
        fork
            begin
                fork
                    run_random(0, 60);
                    run_random(1, 60);
                join
                rand_on = 1'b0;
            end
            while (rand_on) begin
                @(posedge clk); #1;
                out_ready[0] = ($urandom_range(0, 3) != 0);
                out_ready[1] = ($urandom_range(0, 3) != 0);
            end
        join
        out_ready = 2'b11;
        cycles(20);
        check("drain", 0, sb[0].size(), 64'd0);
        check("drain", 1, sb[1].size(), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
